// File: rtl/dvi_pkg.sv
// Shared types and constants for the DVI TMDS raster sequencer and its axis counters.
package dvi_pkg;

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned CNT_MAX = 4096;

    typedef enum logic [1:0] {
        ST_ACT  = 2'd0,
        ST_FP   = 2'd1,
        ST_SYNC = 2'd2,
        ST_BP   = 2'd3
    } axis_st_e;

    localparam logic [7:0] BLANK_DATA = 8'h00;
    localparam logic [9:0] BLANK_IDLE = 10'h000;

    // Blanking word for the blue channel: control bits {c1, c0} = {vs, hs}.
    function automatic logic [9:0] ctrl_word(input logic vs, input logic hs);
        return {vs, hs, BLANK_DATA};
    endfunction

endpackage

// File: rtl/dvi_tmds_sequencer_if.sv
// Pixel-source and encoder-side bundle of the DVI TMDS sequencer.
interface dvi_tmds_sequencer_if;

    logic        enable;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        pix_req;
    logic [9:0]  ch0_in;
    logic        ch0_de;
    logic [9:0]  ch1_in;
    logic        ch1_de;
    logic [9:0]  ch2_in;
    logic        ch2_de;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_cnt;

    modport master (
        input  enable, pix_r, pix_g, pix_b,
        output pix_req, ch0_in, ch0_de, ch1_in, ch1_de, ch2_in, ch2_de,
        output line_start, frame_start, frame_cnt
    );

    modport slave (
        output enable, pix_r, pix_g, pix_b,
        input  pix_req, ch0_in, ch0_de, ch1_in, ch1_de, ch2_in, ch2_de,
        input  line_start, frame_start, frame_cnt
    );

endinterface

// File: rtl/dvi_axis_cnt.sv
// One raster axis: position counter plus ACT/FP/SYNC/BP state, advancing on i_step.
module dvi_axis_cnt
    import dvi_pkg::*;
#(
    parameter int unsigned ACT_LEN  = 640,
    parameter int unsigned FP_LEN   = 16,
    parameter int unsigned SYNC_LEN = 96,
    parameter int unsigned BP_LEN   = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_step,
    output logic [CNT_W-1:0] o_cnt,
    output axis_st_e         o_state,
    output axis_st_e         o_state_d,
    output logic             o_wrap
);

    localparam int unsigned TOTAL = ACT_LEN + FP_LEN + SYNC_LEN + BP_LEN;

    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACT_LEN - 1);
    localparam logic [CNT_W-1:0] FP_END   = CNT_W'(ACT_LEN + FP_LEN - 1);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACT_LEN + FP_LEN + SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);

    if (TOTAL > CNT_MAX || SYNC_LEN == 0 || ACT_LEN == 0) begin : g_param_check
        $error("dvi_axis_cnt: total exceeds counter range or zero-length ACT/SYNC");
    end

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    axis_st_e         r_state;
    axis_st_e         w_state_d;
    logic             w_last;

    assign w_last = (r_cnt == LAST);

    // Zero-width FP/BP are skipped by jumping straight to the following state.
    always_comb begin
        w_cnt_d   = r_cnt;
        w_state_d = r_state;
        if (i_clr) begin
            w_cnt_d   = '0;
            w_state_d = ST_ACT;
        end else if (i_step) begin
            w_cnt_d = w_last ? '0 : r_cnt + 1'b1;
            case (r_state)
                ST_ACT:  if (r_cnt == ACT_END)  w_state_d = (FP_LEN != 0) ? ST_FP : ST_SYNC;
                ST_FP:   if (r_cnt == FP_END)   w_state_d = ST_SYNC;
                ST_SYNC: if (r_cnt == SYNC_END) w_state_d = (BP_LEN != 0) ? ST_BP : ST_ACT;
                ST_BP:   if (w_last)            w_state_d = ST_ACT;
                default:                        w_state_d = ST_ACT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_state <= ST_ACT;
        end else begin
            r_cnt   <= w_cnt_d;
            r_state <= w_state_d;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_state   = r_state;
    assign o_state_d = w_state_d;
    assign o_wrap    = i_step && w_last;

endmodule

// File: rtl/dvi_tmds_sequencer.sv
// DVI raster timing and TMDS encoder-input sequencer (pixel clock domain).
// Optional frame counter enabled by defining DVI_TMDS_SEQ_FRAME_CNT_EN.
module dvi_tmds_sequencer
    import dvi_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dvi_tmds_sequencer_if.master  bus
);

    logic             r_run;
    logic             r_pix_req;
    logic             r_de;
    logic             r_line_start;
    logic             r_frame_start;
    logic [9:0]       r_ch0_in;
    logic [9:0]       r_ch1_in;
    logic [9:0]       r_ch2_in;

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    axis_st_e         w_h_state;
    axis_st_e         w_h_state_d;
    axis_st_e         w_v_state;
    axis_st_e         w_v_state_d;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_clr;
    logic             w_hs;
    logic             w_vs;
    logic             w_act_d;

    assign w_clr = ~bus.enable;

    // Counters hold at origin for the first enabled cycle so h=0/v=0 is shown once.
    dvi_axis_cnt #(
        .ACT_LEN  (H_ACTIVE),
        .FP_LEN   (H_FP),
        .SYNC_LEN (H_SYNC),
        .BP_LEN   (H_BP)
    ) u_h_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_step    (r_run),
        .o_cnt     (w_h_cnt),
        .o_state   (w_h_state),
        .o_state_d (w_h_state_d),
        .o_wrap    (w_h_wrap)
    );

    dvi_axis_cnt #(
        .ACT_LEN  (V_ACTIVE),
        .FP_LEN   (V_FP),
        .SYNC_LEN (V_SYNC),
        .BP_LEN   (V_BP)
    ) u_v_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_step    (w_h_wrap),
        .o_cnt     (w_v_cnt),
        .o_state   (w_v_state),
        .o_state_d (w_v_state_d),
        .o_wrap    (w_v_wrap)
    );

    assign w_hs    = (w_h_state == ST_SYNC) ? HSYNC_POL : ~HSYNC_POL;
    assign w_vs    = (w_v_state == ST_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    assign w_act_d = bus.enable && (w_h_state_d == ST_ACT) && (w_v_state_d == ST_ACT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run         <= 1'b0;
            r_pix_req     <= 1'b0;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_ch0_in      <= ctrl_word(~VSYNC_POL, ~HSYNC_POL);
            r_ch1_in      <= BLANK_IDLE;
            r_ch2_in      <= BLANK_IDLE;
        end else begin
            r_run         <= bus.enable;
            r_pix_req     <= w_act_d;
            r_de          <= r_pix_req;
            r_line_start  <= r_run && (w_h_cnt == '0);
            r_frame_start <= r_run && (w_h_cnt == '0) && (w_v_cnt == '0);
            if (r_pix_req) begin
                r_ch0_in <= {2'b00, bus.pix_b};
                r_ch1_in <= {2'b00, bus.pix_g};
                r_ch2_in <= {2'b00, bus.pix_r};
            end else begin
                r_ch0_in <= ctrl_word(w_vs, w_hs);
                r_ch1_in <= BLANK_IDLE;
                r_ch2_in <= BLANK_IDLE;
            end
        end
    end

`ifdef DVI_TMDS_SEQ_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 16'h0000;
        end else if (bus.enable && w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign bus.frame_cnt = r_frame_cnt;
`else
    logic w_unused_v_wrap;
    assign w_unused_v_wrap = w_v_wrap;
    assign bus.frame_cnt   = 16'h0000;
`endif

    assign bus.pix_req     = r_pix_req;
    assign bus.ch0_in      = r_ch0_in;
    assign bus.ch1_in      = r_ch1_in;
    assign bus.ch2_in      = r_ch2_in;
    assign bus.ch0_de      = r_de;
    assign bus.ch1_de      = r_de;
    assign bus.ch2_de      = r_de;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_dvi_tmds_sequencer.sv
// Self-checking bench for dvi_tmds_sequencer on a tiny 8x6 raster against a position-based model.
module tb_dvi_tmds_sequencer;

    localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FT = HT * VT;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    dvi_tmds_sequencer_if bus ();

    dvi_tmds_sequencer #(
        .H_ACTIVE  (HA),
        .H_FP      (HF),
        .H_SYNC    (HS),
        .H_BP      (HB),
        .V_ACTIVE  (VA),
        .V_FP      (VF),
        .V_SYNC    (VS),
        .V_BP      (VB),
        .HSYNC_POL (1'b0),
        .VSYNC_POL (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: raster position as a flat index into the frame.
    bit          m_live;
    int unsigned m_pos;
    int unsigned m_frames;
    logic        e_req, e_de, e_ls, e_fs;
    logic [9:0]  e_ch0, e_ch1, e_ch2;
    logic [15:0] e_fc;

    function automatic bit in_act(input int unsigned pos);
        return ((pos % HT) < HA) && ((pos / HT) < VA);
    endfunction

    function automatic logic hs_lvl(input int unsigned pos);
        int unsigned h;
        h = pos % HT;
        return !((h >= HA + HF) && (h < HA + HF + HS));
    endfunction

    function automatic logic vs_lvl(input int unsigned pos);
        int unsigned v;
        v = pos / HT;
        return !((v >= VA + VF) && (v < VA + VF + VS));
    endfunction

    task automatic model_reset();
        m_live   = 1'b0;
        m_pos    = 0;
        m_frames = 0;
        e_req    = 1'b0;
        e_de     = 1'b0;
        e_ls     = 1'b0;
        e_fs     = 1'b0;
        e_ch0    = 10'h300;
        e_ch1    = 10'h000;
        e_ch2    = 10'h000;
        e_fc     = 16'h0000;
    endtask

    task automatic model_edge(input bit en, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b);
        e_de  = e_req;
        e_ch0 = e_req ? {2'b00, b} : {vs_lvl(m_pos), hs_lvl(m_pos), 8'h00};
        e_ch1 = e_req ? {2'b00, g} : 10'h000;
        e_ch2 = e_req ? {2'b00, r} : 10'h000;
        e_ls  = m_live && ((m_pos % HT) == 0);
        e_fs  = m_live && (m_pos == 0);
        if (!en) begin
            m_live = 1'b0;
            m_pos  = 0;
        end else if (m_live) begin
            if (m_pos == FT - 1) m_frames++;
            m_pos = (m_pos + 1) % FT;
        end else begin
            m_live = 1'b1;
        end
        e_req = en && in_act(m_pos);
`ifdef DVI_TMDS_SEQ_FRAME_CNT_EN
        e_fc = 16'(m_frames);
`else
        e_fc = 16'h0000;
`endif
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pix_req"},     16'(bus.pix_req),     16'(e_req));
        chk({tag, ".ch0_de"},      16'(bus.ch0_de),      16'(e_de));
        chk({tag, ".ch1_de"},      16'(bus.ch1_de),      16'(e_de));
        chk({tag, ".ch2_de"},      16'(bus.ch2_de),      16'(e_de));
        chk({tag, ".ch0_in"},      16'(bus.ch0_in),      16'(e_ch0));
        chk({tag, ".ch1_in"},      16'(bus.ch1_in),      16'(e_ch1));
        chk({tag, ".ch2_in"},      16'(bus.ch2_in),      16'(e_ch2));
        chk({tag, ".line_start"},  16'(bus.line_start),  16'(e_ls));
        chk({tag, ".frame_start"}, 16'(bus.frame_start), 16'(e_fs));
        chk({tag, ".frame_cnt"},   bus.frame_cnt,        e_fc);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".pix_req"},     16'(bus.pix_req),     16'h0);
        chk({tag, ".de"},          16'(bus.ch0_de | bus.ch1_de | bus.ch2_de), 16'h0);
        chk({tag, ".ch0_in"},      16'(bus.ch0_in),      16'h300);
        chk({tag, ".ch1_in"},      16'(bus.ch1_in),      16'h000);
        chk({tag, ".ch2_in"},      16'(bus.ch2_in),      16'h000);
        chk({tag, ".line_start"},  16'(bus.line_start),  16'h0);
        chk({tag, ".frame_start"}, 16'(bus.frame_start), 16'h0);
        chk({tag, ".frame_cnt"},   bus.frame_cnt,        16'h0);
    endtask

    // Inputs are driven for the current cycle, sampled at the next edge, checked at negedge.
    task automatic step(input bit en, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b);
        bus.enable = en;
        bus.pix_r  = r;
        bus.pix_g  = g;
        bus.pix_b  = b;
        @(posedge clk);
        model_edge(en, r, g, b);
        @(negedge clk);
        cyc++;
        check_all($sformatf("cyc%0d", cyc));
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset(tag);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int          n;
        bit          found;
        logic [7:0]  px;
        logic [15:0] fc_exp;

        bus.enable = 1'b0;
        bus.pix_r  = 8'h00;
        bus.pix_g  = 8'h00;
        bus.pix_b  = 8'h00;
        model_reset();

        #1 rst_n = 1'b0;
        #1 check_reset("por");
        repeat (2) @(negedge clk);
        check_reset("por_hold");
        rst_n = 1'b1;

        repeat (2) step(1'b0, 8'hAA, 8'hBB, 8'hCC);

        // Two frames with pixel value 0x10+n in request cycle n.
        n = 0;
        for (int i = 0; i < int'(2 * FT) + 2; i++) begin
            px = 8'h10 + 8'(n);
            if (e_req) n++;
            step(1'b1, px, px, px);
        end

        // Seek to h=2 of line 1, drop enable during that cycle, then re-enable.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_live && m_pos == HT + 2) found = 1'b1;
            else step(1'b1, 8'(i), 8'(i + 1), 8'(i + 2));
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $error("FAIL seek_line1_h2: observed pos %0d expected %0d", m_pos, HT + 2);
        end
        step(1'b0, 8'h21, 8'h22, 8'h23);
        step(1'b0, 8'h31, 8'h32, 8'h33);
        repeat (2 * FT) step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));

        // Randomized enable and pixel traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 15) != 0, 8'($urandom), 8'($urandom), 8'($urandom));
        end

        async_reset("async_mid");

        // Three complete frames from a fresh start.
        repeat (1 + 3 * FT) step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
`ifdef DVI_TMDS_SEQ_FRAME_CNT_EN
        fc_exp = 16'd3;
`else
        fc_exp = 16'd0;
`endif
        chk("frame_cnt_3", bus.frame_cnt, fc_exp);

        repeat (20) step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        async_reset("async_end");
        repeat (3) step(1'b0, 8'h00, 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
